// File: rtl/chg_fetch_pkg.sv
// chg_fetch_pkg: shared defaults, change-entry layout and FSM encoding for the
// change-list fetcher.
package chg_fetch_pkg;

    localparam int          ADDR_W_DEF  = 10;
    localparam logic [15:0] END_ROW_DEF = 16'hFFFF;
    localparam int          ENTRY_W     = 80;

    // Field order fixes the SRAM word layout: row[79:64] col[63:48] real[47:24] img[23:0]
    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic [23:0] re;
        logic [23:0] im;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/chg_fetch_if.sv
// chg_fetch_if: change-SRAM read port plus the entry hand-off to the Y-update stage.
interface chg_fetch_if
    import chg_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic                 start;
    logic [ENTRY_W-1:0]   chgMem_rdData;
    logic                 chg_ack;
    logic [ADDR_W-1:0]    chgMem_addr;
    logic                 chgMem_rdEn;
    logic [15:0]          chg_row;
    logic [15:0]          chg_col;
    logic [23:0]          chg_real;
    logic [23:0]          chg_img;
    logic                 chg_valid;
    logic                 list_done;
    logic [ADDR_W:0]      entry_count;

    modport master (
        output start, chgMem_rdData, chg_ack,
        input  chgMem_addr, chgMem_rdEn, chg_row, chg_col, chg_real, chg_img,
               chg_valid, list_done, entry_count
    );

    modport slave (
        input  start, chgMem_rdData, chg_ack,
        output chgMem_addr, chgMem_rdEn, chg_row, chg_col, chg_real, chg_img,
               chg_valid, list_done, entry_count
    );

endinterface

// File: rtl/chg_entry_buf.sv
// chg_entry_buf: one-entry prefetch register with full flag and end-of-list detect.
module chg_entry_buf
    import chg_fetch_pkg::*;
#(
    parameter logic [15:0] END_ROW = END_ROW_DEF
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   clr_i,
    input  logic   load_i,
    input  logic   take_i,
    input  entry_t d_i,
    output entry_t q_o,
    output logic   full_o,
    output logic   end_o
);

    entry_t data_q, data_d;
    logic   full_q, full_d;

    always_comb begin
        full_d = (clr_i || take_i) ? 1'b0 : (load_i ? 1'b1 : full_q);
        data_d = load_i ? d_i : data_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign q_o    = data_q;
    assign full_o = full_q;
    assign end_o  = full_q && (data_q.row == END_ROW);

endmodule

// File: rtl/chg_fetch.sv
// chg_fetch: walks the change list in SRAM and presents one entry at a time to the
// Y-update stage, prefetching the following entry so acks can run back to back.
module chg_fetch
    import chg_fetch_pkg::*;
#(
    parameter int          ADDR_W  = ADDR_W_DEF,
    parameter logic [15:0] END_ROW = END_ROW_DEF
) (
    input  logic       clock,
    input  logic       reset,
    chg_fetch_if.slave bus
);

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                exh_q, exh_d;
    logic                pend_q, pend_d;
    logic                valid_q, valid_d;
    entry_t              out_q, out_d;
    entry_t              rd, buf_q;
    logic                rd_en, ack, rd_end;
    logic                buf_full, buf_end, buf_load, buf_take, buf_clr;

    assign rd     = entry_t'(bus.chgMem_rdData);
    assign rd_end = rd.row == END_ROW;
    assign ack    = bus.chg_ack && valid_q;

    chg_entry_buf #(.END_ROW(END_ROW)) u_buf (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (buf_clr),
        .load_i (buf_load),
        .take_i (buf_take),
        .d_i    (rd),
        .q_o    (buf_q),
        .full_o (buf_full),
        .end_o  (buf_end)
    );

    // exh_q marks that the last SRAM address has been read, so the pointer never wraps
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        exh_d    = exh_q;
        pend_d   = 1'b0;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        rd_en    = 1'b0;
        buf_load = 1'b0;
        buf_take = 1'b0;
        buf_clr  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    ptr_d   = '0;
                    exh_d   = 1'b0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    buf_clr = 1'b1;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_d = CAPT;
            end
            CAPT: begin
                state_d = rd_end ? DONE : HOLD;
                valid_d = !rd_end;
                out_d   = rd_end ? out_q : rd;
            end
            HOLD: begin
                rd_en  = !buf_full && !pend_q && !exh_q;
                pend_d = rd_en;
                cnt_d  = ack ? cnt_q + CNT_ONE : cnt_q;
                // Without an ack the presented entry stays put and any capture goes to the buffer
                if (valid_q && !ack) begin
                    buf_load = pend_q;
                end else if (buf_full) begin
                    buf_take = 1'b1;
                    valid_d  = !buf_end;
                    out_d    = buf_end ? out_q : buf_q;
                    state_d  = buf_end ? DONE : HOLD;
                end else if (pend_q) begin
                    valid_d = !rd_end;
                    out_d   = rd_end ? out_q : rd;
                    state_d = rd_end ? DONE : HOLD;
                end else begin
                    valid_d = 1'b0;
                    state_d = exh_q ? DONE : HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rd_en) begin
            ptr_d = ptr_q + PTR_ONE;
            exh_d = &ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            exh_q   <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            exh_q   <= exh_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign bus.chgMem_rdEn = rd_en;
    assign bus.chgMem_addr = ptr_q;
    assign bus.chg_row     = out_q.row;
    assign bus.chg_col     = out_q.col;
    assign bus.chg_real    = out_q.re;
    assign bus.chg_img     = out_q.im;
    assign bus.chg_valid   = valid_q;
    assign bus.list_done   = state_q == DONE;
    assign bus.entry_count = cnt_q;

endmodule

// File: tb/tb_chg_fetch.sv
// tb_chg_fetch: directed table plus hand sequences for the change-list fetcher,
// with a 1024-entry instance and an 8-entry capacity instance.
module tb_chg_fetch;
    import chg_fetch_pkg::*;

    typedef struct {
        logic        start;
        logic        ack;
        logic        rden;
        logic        valid;
        logic        done;
        logic [15:0] row;
        logic [10:0] cnt;
        logic [9:0]  addr;
    } vec_t;

    localparam logic [79:0] END_E = {16'hFFFF, 64'd0};

    logic clk = 1'b0;
    logic reset;
    int errors = 0;
    int checks = 0;
    int rd_a = 0;
    int rd_b = 0;
    logic [79:0] mem_a [0:1023];
    logic [79:0] mem_b [0:7];
    logic [2:0]  addr_b [0:15];

    chg_fetch_if #(.ADDR_W(10)) ia();
    chg_fetch_if #(.ADDR_W(3))  ib();

    chg_fetch #(.ADDR_W(10), .END_ROW(16'hFFFF)) dut_a (.clock(clk), .reset(reset), .bus(ia));
    chg_fetch #(.ADDR_W(3),  .END_ROW(16'hFFFF)) dut_b (.clock(clk), .reset(reset), .bus(ib));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ia.chgMem_rdEn) begin
            ia.chgMem_rdData <= mem_a[ia.chgMem_addr];
            rd_a <= rd_a + 1;
        end
        if (ib.chgMem_rdEn) begin
            ib.chgMem_rdData <= mem_b[ib.chgMem_addr];
            if (rd_b < 16) addr_b[rd_b[3:0]] <= ib.chgMem_addr;
            rd_b <= rd_b + 1;
        end
    end

    function automatic logic [79:0] ent(logic [15:0] r, logic [15:0] c, logic [23:0] re, logic [23:0] im);
        return {r, c, re, im};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_ack();
        ia.chg_ack = 1'b1;
        step();
        ia.chg_ack = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!ia.chg_valid && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(ia.chg_valid), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [12];
        int n;
        int seen;
        int snap;
        reset = 1'b0;
        ia.start = 1'b0;
        ia.chg_ack = 1'b0;
        ib.start = 1'b0;
        ib.chg_ack = 1'b0;
        for (int k = 0; k < 8; k++) mem_b[k] = ent(16'(100 + k), 16'(k), 24'(k), 24'(k));
        mem_a[0] = ent(16'd3, 16'd5, 24'h000100, 24'hFFFF00);
        mem_a[1] = ent(16'd7, 16'd8, 24'h000002, 24'h000003);
        mem_a[2] = ent(16'd11, 16'd12, 24'h800000, 24'h7FFFFF);
        mem_a[3] = END_E;
        step();
        step();
        chk("rst_rden", 32'(ia.chgMem_rdEn), 0);
        chk("rst_addr", 32'(ia.chgMem_addr), 0);
        chk("rst_valid", 32'(ia.chg_valid), 0);
        chk("rst_done", 32'(ia.list_done), 0);
        chk("rst_cnt", 32'(ia.entry_count), 0);
        chk("rst_row", 32'(ia.chg_row), 0);
        chk("rst_img", 32'(ia.chg_img), 0);
        reset = 1'b1;
        step();

        // three entries, ack on the second cycle of each: chg_valid must not gap
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  11'd0, 10'd0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,  11'd0, 10'd0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  11'd0, 10'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3,  11'd0, 10'd1};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3,  11'd0, 10'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd7,  11'd1, 10'd2};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd7,  11'd1, 10'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd11, 11'd2, 10'd3};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd11, 11'd2, 10'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  11'd3, 10'd0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0,  11'd3, 10'd0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  11'd3, 10'd0};
        foreach (vt[i]) begin
            ia.start = vt[i].start;
            ia.chg_ack = vt[i].ack;
            chk($sformatf("tbl%0d_rden", i), 32'(ia.chgMem_rdEn), 32'(vt[i].rden));
            chk($sformatf("tbl%0d_valid", i), 32'(ia.chg_valid), 32'(vt[i].valid));
            chk($sformatf("tbl%0d_done", i), 32'(ia.list_done), 32'(vt[i].done));
            chk($sformatf("tbl%0d_cnt", i), 32'(ia.entry_count), 32'(vt[i].cnt));
            if (vt[i].valid) chk($sformatf("tbl%0d_row", i), 32'(ia.chg_row), 32'(vt[i].row));
            if (vt[i].rden) chk($sformatf("tbl%0d_addr", i), 32'(ia.chgMem_addr), 32'(vt[i].addr));
            step();
        end
        ia.start = 1'b0;
        ia.chg_ack = 1'b0;

        // single entry then end marker, restarted from DONE
        mem_a[1] = END_E;
        ia.start = 1'b1;
        chk("one_done_before", 32'(ia.list_done), 1);
        step();
        ia.start = 1'b0;
        chk("one_rden_t1", 32'(ia.chgMem_rdEn), 1);
        chk("one_addr_t1", 32'(ia.chgMem_addr), 0);
        chk("one_done_cleared", 32'(ia.list_done), 0);
        chk("one_cnt_cleared", 32'(ia.entry_count), 0);
        step();
        chk("one_rden_t2", 32'(ia.chgMem_rdEn), 0);
        chk("one_valid_t2", 32'(ia.chg_valid), 0);
        step();
        chk("one_valid_t3", 32'(ia.chg_valid), 1);
        chk("one_row", 32'(ia.chg_row), 3);
        chk("one_col", 32'(ia.chg_col), 5);
        chk("one_real", 32'(ia.chg_real), 32'h000100);
        chk("one_img", 32'(ia.chg_img), 32'hFFFF00);
        step();
        step();
        chk("one_valid_hold", 32'(ia.chg_valid), 1);
        chk("one_row_hold", 32'(ia.chg_row), 3);
        pulse_ack();
        chk("one_valid_end", 32'(ia.chg_valid), 0);
        chk("one_done_end", 32'(ia.list_done), 1);
        chk("one_cnt_end", 32'(ia.entry_count), 1);

        // ack on the first valid cycle: short gap, no skip or duplicate
        mem_a[0] = ent(16'd20, 16'd1, 24'd1, 24'd1);
        mem_a[1] = ent(16'd21, 16'd2, 24'd2, 24'd2);
        mem_a[2] = END_E;
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        wait_valid("fast_v0", 4);
        chk("fast_row0", 32'(ia.chg_row), 20);
        pulse_ack();
        wait_valid("fast_v1", 2);
        chk("fast_row1", 32'(ia.chg_row), 21);
        chk("fast_cnt1", 32'(ia.entry_count), 1);
        pulse_ack();
        n = 0;
        seen = 0;
        while (!ia.list_done && n < 4) begin
            if (ia.chg_valid) seen = 1;
            step();
            n++;
        end
        chk("fast_done", 32'(ia.list_done), 1);
        chk("fast_no_extra", 32'(seen), 0);
        chk("fast_cnt2", 32'(ia.entry_count), 2);

        // empty list
        mem_a[0] = END_E;
        snap = rd_a;
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        chk("empty_rden_t1", 32'(ia.chgMem_rdEn), 1);
        step();
        chk("empty_valid_t2", 32'(ia.chg_valid), 0);
        chk("empty_done_t2", 32'(ia.list_done), 0);
        step();
        chk("empty_valid_t3", 32'(ia.chg_valid), 0);
        chk("empty_done_t3", 32'(ia.list_done), 1);
        chk("empty_cnt", 32'(ia.entry_count), 0);
        chk("empty_reads", 32'(rd_a - snap), 1);

        // reset in HOLD after two acks, then a fresh walk from address 0
        for (int k = 0; k < 4; k++) mem_a[k] = ent(16'(30 + k), 16'(k), 24'(k), 24'(k));
        mem_a[4] = END_E;
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        wait_valid("rw_v0", 4);
        chk("rw_row0", 32'(ia.chg_row), 30);
        pulse_ack();
        wait_valid("rw_v1", 3);
        chk("rw_row1", 32'(ia.chg_row), 31);
        pulse_ack();
        wait_valid("rw_v2", 3);
        chk("rw_row2", 32'(ia.chg_row), 32);
        chk("rw_cnt2", 32'(ia.entry_count), 2);
        reset = 1'b0;
        step();
        chk("rw_rst_rden", 32'(ia.chgMem_rdEn), 0);
        chk("rw_rst_addr", 32'(ia.chgMem_addr), 0);
        chk("rw_rst_valid", 32'(ia.chg_valid), 0);
        chk("rw_rst_done", 32'(ia.list_done), 0);
        chk("rw_rst_cnt", 32'(ia.entry_count), 0);
        chk("rw_rst_row", 32'(ia.chg_row), 0);
        chk("rw_rst_real", 32'(ia.chg_real), 0);
        reset = 1'b1;
        snap = rd_a;
        step();
        step();
        step();
        chk("rw_no_reads", 32'(rd_a - snap), 0);
        chk("rw_idle_valid", 32'(ia.chg_valid), 0);
        ia.start = 1'b1;
        step();
        ia.start = 1'b0;
        chk("rw_rden", 32'(ia.chgMem_rdEn), 1);
        chk("rw_addr0", 32'(ia.chgMem_addr), 0);
        step();
        step();
        chk("rw_valid", 32'(ia.chg_valid), 1);
        chk("rw_row_again", 32'(ia.chg_row), 30);

        // capacity: 8 entries, no end marker, 3-bit address
        ib.start = 1'b1;
        step();
        ib.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!ib.chg_valid && n < 6) begin
                step();
                n++;
            end
            chk($sformatf("cap_valid%0d", k), 32'(ib.chg_valid), 1);
            chk($sformatf("cap_row%0d", k), 32'(ib.chg_row), 32'(100 + k));
            ib.chg_ack = 1'b1;
            step();
            ib.chg_ack = 1'b0;
        end
        n = 0;
        while (!ib.list_done && n < 4) begin
            step();
            n++;
        end
        chk("cap_done", 32'(ib.list_done), 1);
        chk("cap_cnt", 32'(ib.entry_count), 8);
        step();
        step();
        chk("cap_reads", 32'(rd_b), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("cap_addr%0d", k), 32'(addr_b[k]), 32'(k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
